// File: rtl/dsram_fill.sv
// dsram_fill -- per-way cache data array.
// One line of 8*DATA_BYTES bits per index, host byte writes, a registered
// read port with write-first forwarding, and an internal sequencer that
// assembles a line from FILL_BEATS narrow beats on a valid/ready refill bus.
// Optional build macro: DSRAM_PARITY_EN adds one even-parity bit per stored
// byte and reports per-byte parity errors on rd_perr.
module dsram_fill #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_BYTES = 32,
  parameter int FILL_BEATS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  // read port
  input  logic                                  rd_en,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic [8*DATA_BYTES-1:0]               rd_data,
  output logic                                  rd_valid,
  // host byte-write port
  input  logic                                  wr_en,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [DATA_BYTES-1:0]                 wr_be,
  input  logic [8*DATA_BYTES-1:0]               wr_data,
  // refill port
  input  logic                                  fill_start,
  input  logic [ADDR_WIDTH-1:0]                 fill_addr,
  input  logic                                  fill_valid,
  input  logic [8*(DATA_BYTES/FILL_BEATS)-1:0]  fill_data,
  output logic                                  fill_ready,
  output logic                                  fill_done,
  output logic                                  busy,
  // parity
  output logic [DATA_BYTES-1:0]                 rd_perr,
  input  logic [DATA_BYTES-1:0]                 par_inject
);

  localparam int ENTRIES    = 2 ** ADDR_WIDTH;
  localparam int LINE_W     = 8 * DATA_BYTES;
  localparam int BEAT_BYTES = DATA_BYTES / FILL_BEATS;
  localparam int CNT_W      = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FILL_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] mem [ENTRIES];

  // ---------------------------------------------------------------------------
  // Fill sequencer state
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_WIDTH-1:0] fill_line;
  logic              fill_accept;

  // Merged write request (host write or accepted fill beat) seen by the array
  logic [DATA_BYTES-1:0] wr_line_en;
  logic [ADDR_WIDTH-1:0] wr_line_addr;
  logic [LINE_W-1:0]     wr_line_data;

  // Read-side combinational view
  logic [LINE_W-1:0]     rd_line_old;
  logic [LINE_W-1:0]     rd_line_next;
  logic                  rd_hit;

  assign fill_accept = fill_valid && fill_ready;

  // FSM state register; reset drops any fill in progress back to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: start only from idle, finish on the last accepted beat.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned (which would infer a latch).
    state_next = state;
    unique case (state)
      S_IDLE: if (fill_start) state_next = S_FILL;
      S_FILL: if (fill_accept && (beat_cnt == LAST_BEAT)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: host writes win over fill beats, so a beat stalls while wr_en.
  always_comb begin
    busy       = 1'b0;
    fill_ready = 1'b0;
    fill_done  = 1'b0;
    unique case (state)
      S_FILL: begin
        busy       = 1'b1;
        fill_ready = !wr_en;
      end
      S_DONE:  fill_done = 1'b1;
      default: ;
    endcase
  end

  // Fill line index and beat counter; both captured only on a start from idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples its inputs from before the edge.
    if (reset) begin
      beat_cnt  <= '0;
      fill_line <= '0;
    end else if ((state == S_IDLE) && fill_start) begin
      beat_cnt  <= '0;
      fill_line <= fill_addr;
    end else if (fill_accept) begin
      beat_cnt  <= beat_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write request merge. The two sources never coincide because fill_ready is
  // low whenever wr_en is high; the priority here just mirrors that rule.
  // ---------------------------------------------------------------------------

  // Select the write source and build its per-byte enables.
  always_comb begin
    wr_line_en   = '0;
    wr_line_addr = wr_addr;
    wr_line_data = wr_data;
    if (wr_en) begin
      wr_line_en = wr_be;
    end else if (fill_accept) begin
      wr_line_addr = fill_line;
      wr_line_data = {FILL_BEATS{fill_data}};
      for (int b = 0; b < DATA_BYTES; b++) begin
        wr_line_en[b] = ((b / BEAT_BYTES) == int'(beat_cnt));
      end
    end
  end

  // Byte-granular array update.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; only control state is, so a
    // fill interrupted by reset leaves the bytes it already wrote in place.
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (wr_line_en[b]) begin
        mem[wr_line_addr][8*b +: 8] <= wr_line_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path with write-first forwarding
  // ---------------------------------------------------------------------------

  // Merge same-cycle written bytes over the old array contents.
  always_comb begin
    rd_line_old = mem[rd_addr];
    rd_hit      = (wr_line_addr == rd_addr);
    for (int b = 0; b < DATA_BYTES; b++) begin
      rd_line_next[8*b +: 8] = (rd_hit && wr_line_en[b]) ? wr_line_data[8*b +: 8]
                                                         : rd_line_old[8*b +: 8];
    end
  end

  // Registered read result; data holds between reads, valid pulses per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_line_next;
      end
    end
  end

`ifdef DSRAM_PARITY_EN
  // ---------------------------------------------------------------------------
  // Per-byte even parity
  // ---------------------------------------------------------------------------
  logic [DATA_BYTES-1:0] par_mem [ENTRIES];
  logic [DATA_BYTES-1:0] wr_par;
  logic [DATA_BYTES-1:0] rd_perr_next;

  // Parity to store; injection only corrupts host-written bytes.
  always_comb begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      wr_par[b] = (^wr_line_data[8*b +: 8]) ^ (wr_en & par_inject[b]);
    end
  end

  // Parity bits travel with their bytes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (wr_line_en[b]) begin
        par_mem[wr_line_addr][b] <= wr_par[b];
      end
    end
  end

  // Recompute and compare; forwarded bytes carry freshly computed parity.
  always_comb begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (rd_hit && wr_line_en[b]) begin
        rd_perr_next[b] = 1'b0;
      end else begin
        rd_perr_next[b] = (^rd_line_old[8*b +: 8]) != par_mem[rd_addr][b];
      end
    end
  end

  // Error flags are registered alongside rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_perr <= '0;
    end else if (rd_en) begin
      rd_perr <= rd_perr_next;
    end
  end
`else
  // Parity disabled: no storage, no errors, injection input unused.
  logic unused_par;
  assign unused_par = ^par_inject;
  assign rd_perr    = '0;
`endif

endmodule

// File: tb/tb_dsram_fill.sv
// tb_dsram_fill -- directed self-checking bench for dsram_fill.
// Expected lines are hand-written constants; build with DSRAM_PARITY_EN to
// also exercise the parity path.
module tb_dsram_fill;

  localparam int AW = 13;
  localparam int DB = 32;
  localparam int FB = 4;
  localparam int BB = DB / FB;

  logic            clk = 1'b0;
  logic            reset;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [8*DB-1:0] rd_data;
  logic            rd_valid;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DB-1:0]   wr_be;
  logic [8*DB-1:0] wr_data;
  logic            fill_start;
  logic [AW-1:0]   fill_addr;
  logic            fill_valid;
  logic [8*BB-1:0] fill_data;
  logic            fill_ready;
  logic            fill_done;
  logic            busy;
  logic [DB-1:0]   rd_perr;
  logic [DB-1:0]   par_inject;

  always #5 clk = ~clk;

  dsram_fill #(
    .ADDR_WIDTH(AW),
    .DATA_BYTES(DB),
    .FILL_BEATS(FB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_addr  (fill_addr),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_ready (fill_ready),
    .fill_done  (fill_done),
    .busy       (busy),
    .rd_perr    (rd_perr),
    .par_inject (par_inject)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DB-1:0] be,
                            input logic [8*DB-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_be   = '0;
  endtask

  task automatic read_line(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_be      = '0;
    wr_data    = '0;
    fill_start = 1'b0;
    fill_addr  = '0;
    fill_valid = 1'b0;
    fill_data  = '0;
    par_inject = '0;

    // Reset state
    tick();
    tick();
    check("rst_rd_valid",   rd_valid,   0);
    check("rst_rd_data",    rd_data,    0);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_fill_done",  fill_done,  0);
    check("rst_busy",       busy,       0);
    check("rst_rd_perr",    rd_perr,    0);
    reset = 1'b0;
    tick();

    // Full-line write then read
    host_write(5, {DB{1'b1}}, {DB{8'hA5}});
    read_line(5);
    check("wr_rd_valid", rd_valid, 1);
    check("wr_rd_data",  rd_data,  {DB{8'hA5}});
    check("wr_rd_perr",  rd_perr,  0);
    tick();
    check("idle_rd_valid", rd_valid, 0);
    check("idle_rd_hold",  rd_data,  {DB{8'hA5}});

    // Single byte enable; unselected bytes of wr_data must be ignored
    host_write(5, 32'h0000_0001, {{31{8'hFF}}, 8'h3C});
    read_line(5);
    check("be_rd_data", rd_data, {{31{8'hA5}}, 8'h3C});

    // Same-cycle write and read of line 7: upper half forwarded
    host_write(7, {DB{1'b1}}, {DB{8'h00}});
    wr_en   = 1'b1;
    wr_addr = 7;
    wr_be   = 32'hFFFF_0000;
    wr_data = {DB{8'h11}};
    rd_en   = 1'b1;
    rd_addr = 7;
    tick();
    wr_en   = 1'b0;
    wr_be   = '0;
    rd_en   = 1'b0;
    check("fwd_rd_data",  rd_data,  {{16{8'h11}}, {16{8'h00}}});
    check("fwd_rd_valid", rd_valid, 1);
    read_line(7);
    check("fwd_stored", rd_data, {{16{8'h11}}, {16{8'h00}}});

    // Fill of line 9 with a host-write stall on beat 2
    host_write(9, {DB{1'b1}}, {DB{8'hEE}});
    fill_start = 1'b1;
    fill_addr  = 9;
    tick();
    fill_start = 1'b0;
    check("fill_busy", busy, 1);
    fill_valid = 1'b1;
    fill_data  = {BB{8'h01}};
    #1;
    check("fill_ready_b0", fill_ready, 1);
    tick();
    fill_data  = {BB{8'h02}};
    fill_start = 1'b1;            // ignored while busy
    fill_addr  = 30;
    tick();
    fill_start = 1'b0;
    fill_data  = {BB{8'h03}};
    wr_en      = 1'b1;
    wr_addr    = 20;
    wr_be      = {DB{1'b1}};
    wr_data    = {DB{8'h55}};
    #1;
    check("fill_stall_ready", fill_ready, 0);
    tick();
    wr_en = 1'b0;
    wr_be = '0;
    #1;
    check("fill_ready_b2", fill_ready, 1);
    check("fill_no_done_b2", fill_done, 0);
    tick();
    fill_data = {BB{8'h04}};
    tick();
    fill_valid = 1'b0;
    check("fill_done_pulse", fill_done, 1);
    check("fill_done_busy",  busy,      0);
    check("fill_done_ready", fill_ready, 0);
    fill_start = 1'b1;            // ignored in DONE
    fill_addr  = 40;
    tick();
    fill_start = 1'b0;
    check("fill_done_clear", fill_done, 0);
    tick();
    check("done_start_ignored", busy, 0);
    read_line(9);
    check("fill_line9", rd_data,
          {{BB{8'h04}}, {BB{8'h03}}, {BB{8'h02}}, {BB{8'h01}}});
    read_line(20);
    check("stall_host_line20", rd_data, {DB{8'h55}});

    // Reset in the middle of a fill of line 9
    host_write(9, {DB{1'b1}}, {DB{8'hEE}});
    fill_start = 1'b1;
    fill_addr  = 9;
    tick();
    fill_start = 1'b0;
    fill_valid = 1'b1;
    fill_data  = {BB{8'hA1}};
    tick();
    fill_data  = {BB{8'hA2}};
    tick();
    fill_valid = 1'b0;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    check("mid_rst_busy",     busy,      0);
    check("mid_rst_done",     fill_done, 0);
    check("mid_rst_rd_data",  rd_data,   0);
    tick();
    check("mid_rst_no_done",  fill_done, 0);
    check("mid_rst_idle",     busy,      0);
    read_line(9);
    check("mid_rst_line9", rd_data, {{16{8'hEE}}, {BB{8'hA2}}, {BB{8'hA1}}});

`ifdef DSRAM_PARITY_EN
    // Parity injection on byte 2 of line 3, then clean rewrite
    par_inject = 32'h0000_0004;
    host_write(3, {DB{1'b1}}, {DB{8'h5A}});
    par_inject = '0;
    read_line(3);
    check("par_inject_perr", rd_perr, 32'h0000_0004);
    host_write(3, {DB{1'b1}}, {DB{8'h5A}});
    read_line(3);
    check("par_clean_perr", rd_perr, 0);
`else
    // Parity disabled: injection has no effect
    par_inject = 32'h0000_0004;
    host_write(3, {DB{1'b1}}, {DB{8'h5A}});
    par_inject = '0;
    read_line(3);
    check("nopar_perr", rd_perr, 0);
    check("nopar_data", rd_data, {DB{8'h5A}});
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dsram_fill.md
Name: dsram_fill

Overview:
- Parametrised per-way cache data array, next generation of the single-cycle-fill data SRAM.
- Line width, depth and fill beat count are generic.
- Adds write-first read forwarding, a registered read-valid, and an internal multi-beat fill sequencer, so the array can be filled from a narrow refill bus with a valid/ready handshake.
- Sits beside the tag array, one instance per way.

Parameters:
- ADDR_WIDTH, 13, line index width; ENTRIES = 2**ADDR_WIDTH.
- DATA_BYTES, 32, line width in bytes; line = 8*DATA_BYTES bits.
- FILL_BEATS, 4, beats per line fill; must divide DATA_BYTES; BEAT_BYTES = DATA_BYTES/FILL_BEATS.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read line index.
- rd_data  out  8*DATA_BYTES  read line, valid when rd_valid=1.
- rd_valid  out  1  read result valid, one cycle after rd_en.
- wr_en  in  1  host byte write.
- wr_addr  in  ADDR_WIDTH  host write line index.
- wr_be  in  DATA_BYTES  host byte enables.
- wr_data  in  8*DATA_BYTES  host write data.
- fill_start  in  1  begin line fill.
- fill_addr  in  ADDR_WIDTH  fill line index, sampled on accepted fill_start.
- fill_valid  in  1  fill beat present.
- fill_data  in  8*BEAT_BYTES  fill beat data, beat 0 = lowest bytes.
- fill_ready  out  1  fill beat accepted this cycle when fill_valid=1.
- fill_done  out  1  one-cycle pulse after the last beat is written.
- busy  out  1  fill in progress.
- rd_perr  out  DATA_BYTES  per-byte parity error (see Optional Feature).
- par_inject  in  DATA_BYTES  parity error injection (see Optional Feature).

Behaviour:
- Reset values: rd_valid=0, rd_data=0, fill_ready=0, fill_done=0, busy=0, rd_perr=0, FSM=IDLE, beat counter=0. Array contents are not cleared.
- Read path:
  - rd_en sampled at edge N; rd_data/rd_valid update at edge N, usable in cycle N+1 (1-cycle load/use).
  - rd_valid=0 when no read was issued; rd_data holds its last value.
- Write-first forwarding:
  - Applies when a write (host or fill beat) targets rd_addr in the same cycle as rd_en.
  - rd_data returns the merged line: written bytes take the new data, others the old array data.
- Host write: bytes with wr_be[i]=1 at wr_addr are updated at the edge; wr_be=0 means no change.
- Fill FSM:
  - IDLE: busy=0, fill_ready=0. fill_start=1 latches fill_addr, clears the beat counter, goes to FILL.
  - FILL: busy=1. fill_ready = !wr_en (host write has priority; beat stalls).
    - Beat accepted on fill_valid && fill_ready.
    - Accepted beat k writes bytes [k*BEAT_BYTES +: BEAT_BYTES] of the latched line; counter increments.
    - On beat FILL_BEATS-1 goes to DONE.
  - DONE: fill_done=1, busy=0 for one cycle, fill_ready=0, then IDLE. fill_start in DONE is ignored.
- fill_start while busy: ignored; latched address unchanged.
- Host write to the line being filled: allowed. Later fill beats overwrite their slice.
- Reset mid-fill: FSM to IDLE next edge. The partially written line keeps the bytes already written. No fill_done.
- FILL_BEATS=1: one accepted beat writes the full line, then DONE.
- Counter width: clog2(FILL_BEATS), minimum 1 bit. Wraps to 0 on entry to FILL.

Optional Feature:
- Macro: DSRAM_PARITY_EN.
- Enabled:
  - One even-parity bit stored per byte, written with the byte from either write source.
  - Stored parity = ^byte ^ par_inject[i] (host writes only).
  - On read, rd_perr[i] = recomputed parity != stored parity, registered with rd_data.
  - Forwarded bytes use the parity of the new data.
- Disabled: no parity storage; rd_perr tied to 0; par_inject ignored.

Test Plan:
- Write/read: wr_addr=5, wr_be=all ones, wr_data=line of 0xA5 bytes; next cycle rd_addr=5 -> following cycle rd_valid=1, rd_data=all 0xA5.
- Byte enables: line 5 = 0xA5s; write wr_be=32'h0000_0001, wr_data byte0=0x3C -> read gives byte0=0x3C, bytes1..31=0xA5.
- Forwarding: same cycle wr_en to addr 7 (be=32'hFFFF_0000, data 0x11s) and rd_en addr 7 (old 0x00s) -> rd_data upper 16 bytes 0x11, lower 16 bytes 0x00.
- Fill with stall:
  - fill_start addr 9, beats 0x01..0x04 (BEAT_BYTES=8, each beat all that value); wr_en asserted during beat 2.
  - Required: fill_ready=0 that cycle; fill_done pulses one cycle after beat 3 accepted; read 9 = bytes0-7=0x01 … bytes24-31=0x04.
- Reset mid-fill: reset after 2 beats -> busy=0 next cycle, no fill_done; read 9 shows beats 0-1 new, rest old; fill_start in the same cycle as busy ignored.
- Parity (DSRAM_PARITY_EN): write addr 3 with par_inject=32'h0000_0004 -> read 3 gives rd_perr=32'h0000_0004; rewrite without inject -> rd_perr=0.
